lfsr_rand_arbiter: RTL and testbench

Shares one 5-bit LFSR random source between two requesters and sequences when it advances. The block embeds the LFSR state register and steps it on two kinds of event: once per served request, and optionally on a free-running tick while idle. Each requester gets a fresh value through a req/ack handshake, with round-robin arbitration between them. It sits between the random source and the game/sequence logic that consumes random numbers, and replaces ad-hoc direct taps of the LFSR output.

---
 rtl/lfsr_rand_arbiter_if.sv | 28 ++
 rtl/lfsr_rand_arbiter.sv | 111 +++++++++++
 tb/tb_lfsr_rand_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rand_arbiter_if.sv
// Request/acknowledge bundle between the shared random source and its two
// consumers, plus the seed load path and the LFSR observe port.
//   req0/req1    consumer requests, held until the matching ack
//   ack0/ack1    one-cycle delivery pulses
//   rnd_out      last delivered random value
//   seed_load    load seed_val into the LFSR
//   seed_val     seed value (zero is replaced by the block's SEED)
//   lfsr_state   current LFSR contents
interface lfsr_rand_arbiter_if;
   logic       req0;
   logic       req1;
   logic       ack0;
   logic       ack1;
   logic [4:0] rnd_out;
   logic       seed_load;
   logic [4:0] seed_val;
   logic [4:0] lfsr_state;

   modport master (
      output req0, req1, seed_load, seed_val,
      input  ack0, ack1, rnd_out, lfsr_state
   );

   modport slave (
      input  req0, req1, seed_load, seed_val,
      output ack0, ack1, rnd_out, lfsr_state
   );
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// Shares one 5-bit maximal-length LFSR between two requesters. Each served
// request steps the LFSR once and delivers the new value on rnd_out with an
// ack pulse; requesters are arbitrated round-robin. With TICK_DIV > 0 the
// LFSR also free-runs one step every TICK_DIV cycles while nothing is served.
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   lfsr_rand_arbiter_if.slave (req/ack, rnd_out, seed load, observe)
//
// state | meaning
// IDLE  | waiting for a request; free-run ticks may step the LFSR
// STEP  | request granted, LFSR steps this edge and ack is raised
// ACK   | ack pulse visible for the granted requester
module lfsr_rand_arbiter #(
   parameter int unsigned TICK_DIV = 5,
   parameter logic [4:0]  SEED     = 5'h08
) (
   input logic                clk,
   input logic                rst,
   lfsr_rand_arbiter_if.slave bus
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LOAD = (TICK_DIV != 0) ? CW'(TICK_DIV - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t        state;
   logic [4:0]    lfsr;
   logic [4:0]    rnd_q;
   logic          ack0_q;
   logic          ack1_q;
   // Id of the most recently granted requester; also selects who is acked.
   logic          last_grant;
   // Down-counter; the free-run tick fires when it reaches zero.
   logic [CW-1:0] tick_cnt;

   logic       tick_fire;
   logic       any_req;
   logic       grant_id;
   logic [4:0] seed_eff;
   logic [4:0] lfsr_next;

   assign lfsr_next = {lfsr[0] ^ lfsr[2], lfsr[4:1]};
   assign tick_fire = (TICK_DIV != 0) && (tick_cnt == '0);
   assign any_req   = bus.req0 | bus.req1;
   // Contention goes to whoever was not served last.
   assign grant_id  = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
   // An all-zero seed would lock the LFSR up, so substitute the default.
   assign seed_eff  = (bus.seed_val == 5'h00) ? SEED : bus.seed_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= SEED;
         rnd_q      <= 5'h00;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         last_grant <= 1'b1;
         tick_cnt   <= TICK_LOAD;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;

         if (bus.seed_load || tick_cnt == '0) begin
            tick_cnt <= TICK_LOAD;
         end else begin
            tick_cnt <= tick_cnt - CW'(1);
         end

         if (bus.seed_load) begin
            // Aborts any transaction in flight without an ack.
            lfsr  <= seed_eff;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (any_req) begin
                     last_grant <= grant_id;
                     state      <= STEP;
                  end else if (tick_fire) begin
                     lfsr <= lfsr_next;
                  end
               end
               STEP: begin
                  lfsr   <= lfsr_next;
                  rnd_q  <= lfsr_next;
                  ack0_q <= ~last_grant;
                  ack1_q <= last_grant;
                  state  <= ACK;
               end
               ACK: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ack0       = ack0_q;
   assign bus.ack1       = ack1_q;
   assign bus.rnd_out    = rnd_q;
   assign bus.lfsr_state = lfsr;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter: one instance with free-run disabled and one
// with TICK_DIV=5, both driven by the same stimulus and checked every cycle
// against a behavioural model, plus literal checks of known values.
module tb_lfsr_rand_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       seed_load;
   logic [4:0] seed_val;
   logic       req0;
   logic       req1;
   logic       chk_en;

   lfsr_rand_arbiter_if bus0();
   lfsr_rand_arbiter_if bus5();

   assign bus0.req0      = req0;
   assign bus0.req1      = req1;
   assign bus0.seed_load = seed_load;
   assign bus0.seed_val  = seed_val;
   assign bus5.req0      = req0;
   assign bus5.req1      = req1;
   assign bus5.seed_load = seed_load;
   assign bus5.seed_val  = seed_val;

   lfsr_rand_arbiter #(.TICK_DIV(0), .SEED(5'h08)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   lfsr_rand_arbiter #(.TICK_DIV(5), .SEED(5'h08)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase counts cycles since a grant: 0 idle, 1 stepping, 2 acking.
   typedef struct packed {
      logic [1:0] phase;
      logic       last;
      logic [4:0] lfsr;
      logic [4:0] rnd;
      logic       a0;
      logic       a1;
      logic [7:0] tick;
   } mdl_t;

   mdl_t m0 = '0;
   mdl_t m5 = '0;

   function automatic logic [4:0] nxt(input logic [4:0] s);
      return (s >> 1) | {s[0] ^ s[2], 4'b0000};
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input int period, input logic r,
                                  input logic sl, input logic [4:0] sv,
                                  input logic q0, input logic q1);
      mdl_t n;
      logic tick_now;
      n    = m;
      n.a0 = 1'b0;
      n.a1 = 1'b0;
      if (r) begin
         n.phase = 2'd0; n.last = 1'b1; n.lfsr = 5'h08; n.rnd = 5'h00; n.tick = 8'd0;
         return n;
      end
      tick_now = (period > 0) && (int'(m.tick) == period - 1);
      if (period > 0) n.tick = tick_now ? 8'd0 : m.tick + 8'd1;
      if (sl) begin
         n.tick  = 8'd0;
         n.lfsr  = (sv == 5'h00) ? 5'h08 : sv;
         n.phase = 2'd0;
         return n;
      end
      case (m.phase)
         2'd0: begin
            if (q0 || q1) begin
               n.last  = (q0 && q1) ? !m.last : q1;
               n.phase = 2'd1;
            end else if (tick_now) begin
               n.lfsr = nxt(m.lfsr);
            end
         end
         2'd1: begin
            n.lfsr  = nxt(m.lfsr);
            n.rnd   = n.lfsr;
            n.a0    = !m.last;
            n.a1    = m.last;
            n.phase = 2'd2;
         end
         default: n.phase = 2'd0;
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      m0 <= mstep(m0, 0, rst, seed_load, seed_val, req0, req1);
      m5 <= mstep(m5, 5, rst, seed_load, seed_val, req0, req1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("dut0_cycle", 32'({bus0.ack0, bus0.ack1, bus0.rnd_out, bus0.lfsr_state}),
             32'({m0.a0, m0.a1, m0.rnd, m0.lfsr}));
         chk("dut5_cycle", 32'({bus5.ack0, bus5.ack1, bus5.rnd_out, bus5.lfsr_state}),
             32'({m5.a0, m5.a1, m5.rnd, m5.lfsr}));
      end
   end

   // ---------------- helpers ----------------
   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic which, output int n, output logic [4:0] r);
      logic seen;
      seen = 1'b0;
      n    = 0;
      r    = 5'h00;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick1();
         n++;
         if (which ? bus0.ack1 : bus0.ack0) begin
            seen = 1'b1;
            r    = bus0.rnd_out;
         end
      end
      if (!seen) chk("ack_timeout", 32'(0), 32'(1));
   endtask

   task automatic serve_both(output int t0, output int t1, output logic [4:0] r0, output logic [4:0] r1);
      logic g0, g1;
      g0 = 1'b0; g1 = 1'b0;
      t0 = 0; t1 = 0; r0 = 5'h00; r1 = 5'h00;
      for (int c = 1; c <= 30 && !(g0 && g1); c++) begin
         tick1();
         if (bus0.ack0 && !g0) begin t0 = c; r0 = bus0.rnd_out; req0 = 1'b0; g0 = 1'b1; end
         if (bus0.ack1 && !g1) begin t1 = c; r1 = bus0.rnd_out; req1 = 1'b0; g1 = 1'b1; end
      end
      if (!(g0 && g1)) chk("both_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int          n, t0, t1, changes;
      logic [4:0]  r, ra, rb, v, prev;
      logic [31:0] seen;

      rst = 1'b1; seed_load = 1'b0; seed_val = 5'h00; req0 = 1'b0; req1 = 1'b0; chk_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_lfsr", 32'(bus0.lfsr_state), 32'h08);
      chk("rst_rnd", 32'(bus0.rnd_out), 32'h00);
      chk("rst_acks", 32'({bus0.ack0, bus0.ack1}), 32'h0);
      rst = 1'b0;

      // Idle: dut0 holds its seed, dut5 free-runs through the full period.
      prev = bus5.lfsr_state; changes = 0; seen = '0;
      seen[prev] = 1'b1;
      for (int c = 1; c <= 155; c++) begin
         tick1();
         v = bus5.lfsr_state;
         if (v != prev) changes++;
         seen[v] = 1'b1;
         prev = v;
         if (c == 20) chk("idle_hold20", 32'(bus0.lfsr_state), 32'h08);
      end
      chk("free_run_changes", 32'(changes), 32'd31);
      chk("free_run_distinct", 32'($countones(seen)), 32'd31);
      chk("free_run_no_zero", 32'(seen[0]), 32'd0);
      chk("free_run_wrap", 32'(bus5.lfsr_state), 32'h08);
      chk("model_wrap", 32'(m5.lfsr), 32'h08);

      // Single requests.
      req0 = 1'b1;
      wait_ack(1'b0, n, r);
      req0 = 1'b0;
      chk("req0_latency", 32'(n), 32'd2);
      chk("req0_rnd", 32'(r), 32'h04);
      chk("model_req0_rnd", 32'(m0.rnd), 32'h04);
      tick1();
      req1 = 1'b1;
      wait_ack(1'b1, n, r);
      req1 = 1'b0;
      chk("req1_latency", 32'(n), 32'd2);
      chk("req1_rnd", 32'(r), 32'h12);
      tick1();

      // Both held from reset.
      rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
      tick1();
      rst = 1'b0;
      serve_both(t0, t1, ra, rb);
      chk("both1_order", 32'(t0 < t1), 32'd1);
      chk("both1_gap", 32'(t1 - t0), 32'd3);
      chk("both1_rnd0", 32'(ra), 32'h04);
      chk("both1_rnd1", 32'(rb), 32'h12);
      tick1();
      req0 = 1'b1; req1 = 1'b1;
      serve_both(t0, t1, ra, rb);
      chk("both2_order", 32'(t0 < t1), 32'd1);
      chk("both2_gap", 32'(t1 - t0), 32'd3);
      chk("both2_rnd0", 32'(ra), 32'h09);
      chk("both2_rnd1", 32'(rb), 32'h14);
      tick1();

      // Seed loads.
      seed_load = 1'b1; seed_val = 5'h00;
      tick1();
      seed_load = 1'b0;
      chk("seed_zero", 32'(bus0.lfsr_state), 32'h08);
      chk("seed_keeps_rnd", 32'(bus0.rnd_out), 32'h14);
      seed_load = 1'b1; seed_val = 5'h1F;
      tick1();
      seed_load = 1'b0;
      chk("seed_1f", 32'(bus0.lfsr_state), 32'h1F);
      req0 = 1'b1;
      wait_ack(1'b0, n, r);
      req0 = 1'b0;
      chk("seed_1f_step", 32'(r), 32'h0F);
      tick1();

      // Seed load during STEP aborts, then re-grant; reset during ACK.
      rst = 1'b1;
      tick1();
      rst = 1'b0; req0 = 1'b1;
      tick1();
      seed_load = 1'b1; seed_val = 5'h03;
      tick1();
      seed_load = 1'b0;
      chk("abort_no_ack", 32'(bus0.ack0), 32'd0);
      chk("abort_lfsr", 32'(bus0.lfsr_state), 32'h03);
      wait_ack(1'b0, n, r);
      chk("regrant_latency", 32'(n), 32'd2);
      chk("regrant_rnd", 32'(r), 32'h11);
      rst = 1'b1; req0 = 1'b0;
      tick1();
      chk("rst_in_ack_ack0", 32'(bus0.ack0), 32'd0);
      chk("rst_in_ack_rnd", 32'(bus0.rnd_out), 32'h00);
      rst = 1'b0;

      // Randomised traffic with occasional seed loads and resets.
      for (int c = 0; c < 3000; c++) begin
         tick1();
         if (req0 && m0.a0) req0 = 1'b0;
         else if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
         if (req1 && m0.a1) req1 = 1'b0;
         else if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
         seed_load = ($urandom_range(40) == 0);
         seed_val  = 5'($urandom);
         rst       = ($urandom_range(300) == 0);
      end
      rst = 1'b0; seed_load = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (5) tick1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
